audio_sample_pacer: RTL and testbench
=====================================

Name: audio_sample_pacer

Overview:
- Elastic sample buffer between the effect stage (`eff_1`, or the bypass mux) and `dac_driver`.
- Absorbs bursty 16-bit samples arriving on `data_ready` strobes.
- Releases them at a fixed sample rate derived from the 25 MHz clock.
- Converts each sample to 12-bit offset-binary for the DAC and reports overflow/underrun.

Parameters:
- `clock_max`, 25_000_000, system clock frequency in Hz.
- `sample_rate`, 8000, output sample rate in Hz; divider DIV = `clock_max`/`sample_rate` (integer, ≥2).
- `DEPTH`, 16, FIFO depth in samples; power of two, ≥4.

Ports:
- `clk_25mhz`  input  1  system clock
- `reset`  input  1  asynchronous, active-low reset
- `in_valid`  input  1  one-cycle strobe: `in_sample` valid (from effect `data_ready`)
- `in_sample`  input  16  signed two's-complement audio sample
- `out_ready`  input  1  DAC driver can accept a sample this cycle
- `out_valid`  output  1  `out_sample` valid, held until accepted
- `out_sample`  output  12  unsigned offset-binary DAC code
- `fifo_level`  output  $clog2(DEPTH)+1  current occupancy
- `overflow`  output  1  sticky: an input sample was dropped
- `underrun`  output  1  sticky: a tick found the FIFO empty
- `clear_flags`  input  1  synchronous clear of `overflow`/`underrun`

Behaviour:
- **Reset (async, `reset`=0):**
  - `out_valid`=0, `out_sample`=12'h800, `fifo_level`=0, `overflow`=0, `underrun`=0.
  - Tick counter=0, FIFO pointers=0, last-sample register=12'h800, state=PREFILL.
  - Reset mid-operation discards all buffered data immediately.
- **Tick:**
  - Counter runs 0..DIV-1 and wraps.
  - tick=1 for one cycle when the counter equals DIV-1.
  - Counter is free-running in all states.
- **Push:**
  - `in_valid`=1 and not full → write, level+1.
  - Full with no simultaneous pop → sample dropped, `overflow`←1.
  - Full with a simultaneous pop → push accepted, level unchanged.
- **Conversion:** `out_sample` = {~`in_sample`[15], `in_sample`[14:4]}, truncation, no rounding. 0x8000→0x000, 0x0000→0x800, 0x7FFF→0xFFF.
- **FSM:**
  - PREFILL:
    - `out_valid`=0; ticks ignored.
    - → RUN when level ≥ DEPTH/2.
  - RUN, on tick:
    - Non-empty → pop, register the converted sample into `out_sample` and the last-sample register, `out_valid`←1 the next cycle, → HOLD.
    - Empty → `underrun`←1, re-present the last sample (see Optional Feature), `out_valid`←1, → HOLD.
  - HOLD:
    - `out_sample` stable while `out_valid`=1.
    - Handshake completes when `out_valid` & `out_ready` → `out_valid`←0 next cycle, → RUN.
    - Ticks arriving in HOLD are discarded: no pop, no flag.
    - Tick and handshake in the same cycle → tick discarded.
  - No return to PREFILL except by reset.
- **Latency:** tick edge → `out_valid` high 1 cycle later. FIFO write → readable on the next cycle.
- **Flags:**
  - Sticky until `clear_flags`=1.
  - Setting event and `clear_flags` in the same cycle → flag ends at 1.
- **Level and pointers:**
  - `fifo_level` is registered and updates the cycle after push/pop.
  - Pointers wrap modulo DEPTH.

Optional Feature:
- Macro: `AUDIO_PACER_UNDERRUN_ZERO_EN`.
- Defined: an underrun tick outputs midscale 12'h800 (silence) and sets the last-sample register to 12'h800.
- Undefined: an underrun tick repeats the last-sample register value.
- `underrun` flag behaviour is identical in both builds.

Test Plan:
All scenarios use `clock_max`=100, `sample_rate`=10 (DIV=10), DEPTH=4.
1. Reset: drive `reset`=0 mid-stream with level=3 → same-cycle `out_valid`=0, `out_sample`=0x800, `fifo_level`=0, flags 0; after release, no output until 2 new samples are pushed.
2. Prefill and conversion:
   - Stimulus: push 0x8000 then 0x7FF0, `out_ready`=1.
   - Required: first tick after level=2 → `out_sample`=0x000; next tick → 0xFFF; `fifo_level` goes 2→1→0.
3. Overflow: push 5 samples on consecutive cycles in PREFILL → `fifo_level`=4, 5th dropped, `overflow`=1; `clear_flags` pulse → 0.
4. Underrun:
   - Stimulus: drain the FIFO (last sample 0x1230 → 0x923), then one more tick.
   - Required: `underrun`=1. `out_sample`=0x923 with the macro undefined; 0x800 with it defined.
5. Backpressure: hold `out_ready`=0 for 25 cycles spanning 2 ticks → `out_valid` stays 1, `out_sample` stable, `fifo_level` unchanged; after `out_ready`=1, exactly one handshake, and the next pop happens on the following tick.
6. Full plus simultaneous push/pop: in RUN with level=4, assert `in_valid` on a tick cycle → push accepted, level stays 4, `overflow` stays 0.

Source files
------------

// File: rtl/audio_sample_pacer.sv
// Elastic sample buffer that paces bursty audio samples out to the DAC.
// Build option: AUDIO_PACER_UNDERRUN_ZERO_EN outputs midscale on underrun.
module audio_sample_pacer #(
   parameter int clock_max   = 25_000_000,
   parameter int sample_rate = 8000,
   parameter int DEPTH       = 16
) (
   input  logic                     clk_25mhz,
   input  logic                     reset,
   input  logic                     in_valid,
   input  logic [15:0]              in_sample,
   input  logic                     out_ready,
   output logic                     out_valid,
   output logic [11:0]              out_sample,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic                     overflow,
   output logic                     underrun,
   input  logic                     clear_flags
);

   localparam int DIV = clock_max / sample_rate;
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int AW  = $clog2(DEPTH);
   localparam int LW  = AW + 1;
   localparam logic [11:0] MID = 12'h800;

   typedef enum logic [1:0] {
      PREFILL,
      RUN,
      HOLD
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]   level_q, level_d;
   logic            out_valid_q, out_valid_d;
   logic [11:0]     out_sample_q, out_sample_d;
   logic [11:0]     last_q, last_d;
   logic            overflow_q, overflow_d;
   logic            underrun_q, underrun_d;
   logic [11:0]     mem_q [DEPTH];

   logic            tick;
   logic            full;
   logic            empty;
   logic            push;
   logic            pop;
   logic            ovf_set;
   logic            und_set;
   logic [11:0]     in_code;
   logic            unused_lsbs;

   assign tick  = (cnt_q == CW'(DIV - 1));
   assign full  = (level_q == LW'(DEPTH));
   assign empty = (level_q == '0);

   // Offset-binary DAC code: flip the sign bit, drop the four LSBs.
   assign in_code     = {~in_sample[15], in_sample[14:4]};
   assign unused_lsbs = ^in_sample[3:0];

   // Free-running sample-rate divider.
   always_comb begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
   end

   // Pacing FSM: prefill, wait for a tick, then hold until accepted.
   always_comb begin
      state_d      = state_q;
      out_valid_d  = out_valid_q;
      out_sample_d = out_sample_q;
      last_d       = last_q;
      pop          = 1'b0;
      und_set      = 1'b0;
      unique case (state_q)
         PREFILL: begin
            if (level_q >= LW'(DEPTH / 2)) state_d = RUN;
         end
         RUN: begin
            if (tick) begin
               out_valid_d = 1'b1;
               state_d     = HOLD;
               if (!empty) begin
                  pop          = 1'b1;
                  out_sample_d = mem_q[rd_ptr_q];
                  last_d       = mem_q[rd_ptr_q];
               end else begin
                  und_set = 1'b1;
`ifdef AUDIO_PACER_UNDERRUN_ZERO_EN
                  out_sample_d = MID;
                  last_d       = MID;
`else
                  out_sample_d = last_q;
`endif
               end
            end
         end
         HOLD: begin
            if (out_valid_q && out_ready) begin
               out_valid_d = 1'b0;
               state_d     = RUN;
            end
         end
         default: state_d = PREFILL;
      endcase
   end

   // FIFO bookkeeping and sticky error flags.
   always_comb begin
      push       = in_valid && (!full || pop);
      ovf_set    = in_valid && full && !pop;
      wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      level_d    = level_q;
      unique case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
      overflow_d = ovf_set | (overflow_q & ~clear_flags);
      underrun_d = und_set | (underrun_q & ~clear_flags);
   end

   // Sample storage; occupancy is tracked by the pointers, so no reset.
   always_ff @(posedge clk_25mhz) begin
      if (push) mem_q[wr_ptr_q] <= in_code;
   end

   // State registers.
   always_ff @(posedge clk_25mhz or negedge reset) begin
      if (!reset) begin
         state_q      <= PREFILL;
         cnt_q        <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         level_q      <= '0;
         out_valid_q  <= 1'b0;
         out_sample_q <= MID;
         last_q       <= MID;
         overflow_q   <= 1'b0;
         underrun_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         level_q      <= level_d;
         out_valid_q  <= out_valid_d;
         out_sample_q <= out_sample_d;
         last_q       <= last_d;
         overflow_q   <= overflow_d;
         underrun_q   <= underrun_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_sample = out_sample_q;
   assign fifo_level = level_q;
   assign overflow   = overflow_q;
   assign underrun   = underrun_q;

endmodule

// File: tb/tb_audio_sample_pacer.sv
// Bench for audio_sample_pacer: queue-based reference model and
// scoreboard, directed scenarios followed by randomized traffic.
module tb_audio_sample_pacer;

   localparam int DIV   = 10;
   localparam int DEPTH = 4;
`ifdef AUDIO_PACER_UNDERRUN_ZERO_EN
   localparam logic [11:0] UND_EXP = 12'h800;
`else
   localparam logic [11:0] UND_EXP = 12'h923;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_valid = 1'b0;
   logic [15:0] in_sample = '0;
   logic        out_ready = 1'b0;
   logic        clear_flags = 1'b0;
   logic        out_valid;
   logic [11:0] out_sample;
   logic [2:0]  fifo_level;
   logic        overflow;
   logic        underrun;

   int n_chk = 0;
   int n_fail = 0;

   // reference model state
   int unsigned  n_edges;
   bit           started;
   bit           presenting;
   bit           m_ovf;
   bit           m_und;
   logic [11:0]  shown;
   logic [11:0]  last;
   logic [15:0]  q[$];
   logic [11:0]  exp_q[$];

   audio_sample_pacer #(
      .clock_max  (100),
      .sample_rate(10),
      .DEPTH      (DEPTH)
   ) dut (
      .clk_25mhz  (clk),
      .reset      (rst_n),
      .in_valid   (in_valid),
      .in_sample  (in_sample),
      .out_ready  (out_ready),
      .out_valid  (out_valid),
      .out_sample (out_sample),
      .fifo_level (fifo_level),
      .overflow   (overflow),
      .underrun   (underrun),
      .clear_flags(clear_flags)
   );

   always #5 clk = ~clk;

   function automatic logic [11:0] dac_code(logic [15:0] s);
      int v;
      v = int'($signed(s)) + 32768;
      return 12'(v / 16);
   endfunction

   task automatic check(string name, int act, int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                  name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      exp_q.delete();
      n_edges    = 0;
      started    = 0;
      presenting = 0;
      m_ovf      = 0;
      m_und      = 0;
      shown      = 12'h800;
      last       = 12'h800;
   endtask

   task automatic advance(bit iv, logic [15:0] s, bit ordy, bit clr);
      bit tick;
      bit popped;
      bit oe;
      bit ue;
      int sz;
      tick   = (n_edges % DIV) == DIV - 1;
      popped = 0;
      oe     = 0;
      ue     = 0;
      sz     = q.size();
      if (!started) begin
         if (sz >= DEPTH / 2) started = 1;
      end else if (!presenting) begin
         if (tick) begin
            if (sz > 0) begin
               shown  = dac_code(q.pop_front());
               last   = shown;
               popped = 1;
            end else begin
               ue = 1;
`ifdef AUDIO_PACER_UNDERRUN_ZERO_EN
               last = 12'h800;
`endif
               shown = last;
            end
            presenting = 1;
            exp_q.push_back(shown);
         end
      end else if (ordy) begin
         presenting = 0;
      end
      if (iv) begin
         if (sz < DEPTH || popped) q.push_back(s);
         else oe = 1;
      end
      m_ovf = oe | (m_ovf & !clr);
      m_und = ue | (m_und & !clr);
      n_edges++;
   endtask

   task automatic cycle(bit iv, logic [15:0] s, bit ordy, bit clr);
      in_valid    = iv;
      in_sample   = s;
      out_ready   = ordy;
      clear_flags = clr;
      advance(iv, s, ordy, clr);
      @(negedge clk);
      #1;
      check("level", int'(fifo_level), q.size());
      check("overflow", int'(overflow), int'(m_ovf));
      check("underrun", int'(underrun), int'(m_und));
      check("out_valid", int'(out_valid), int'(presenting));
      check("out_sample", int'(out_sample), int'(shown));
   endtask

   task automatic do_reset(int hold);
      in_valid    = 0;
      out_ready   = 0;
      clear_flags = 0;
      rst_n       = 0;
      #1;
      check("rst_valid", int'(out_valid), 0);
      check("rst_sample", int'(out_sample), 'h800);
      check("rst_level", int'(fifo_level), 0);
      check("rst_ovf", int'(overflow), 0);
      check("rst_und", int'(underrun), 0);
      model_reset();
      repeat (hold) @(negedge clk);
      #1;
      rst_n = 1;
   endtask

   task automatic idle_until_tick();
      for (int i = 0; i < DIV; i++) begin
         if ((n_edges % DIV) == DIV - 1) break;
         cycle(0, '0, 1, 0);
      end
   endtask

   // scoreboard monitor: one compare per new presentation
   initial begin
      logic        prev_v;
      logic [11:0] e;
      prev_v = 0;
      forever begin
         @(negedge clk);
         if (out_valid === 1'b1 && prev_v !== 1'b1) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_output: got 0x%0h expected none",
                        out_sample);
            end else begin
               e = exp_q.pop_front();
               check("sample", int'(out_sample), int'(e));
            end
         end
         prev_v = out_valid;
      end
   end

   initial begin
      model_reset();
      @(negedge clk);
      #1;
      do_reset(3);

      // prefill then conversion of the extremes
      cycle(1, 16'h8000, 1, 0);
      cycle(1, 16'h7FF0, 1, 0);
      repeat (30) cycle(0, '0, 1, 0);

      // drain to underrun
      do_reset(2);
      cycle(1, 16'h0000, 1, 0);
      cycle(1, 16'h1230, 1, 0);
      repeat (35) cycle(0, '0, 1, 0);
      check("und_flag", int'(underrun), 1);
      check("und_sample", int'(out_sample), int'(UND_EXP));

      // reset mid-stream with three buffered
      do_reset(2);
      repeat (3) cycle(1, 16'($urandom), 1, 0);
      check("lvl3", int'(fifo_level), 3);
      do_reset(2);
      repeat (15) cycle(0, '0, 1, 0);
      cycle(1, 16'h4000, 1, 0);
      repeat (15) cycle(0, '0, 1, 0);
      check("no_out_one", int'(out_valid), 0);

      // overflow in the fill phase, then clear
      do_reset(2);
      repeat (5) cycle(1, 16'($urandom), 1, 0);
      check("ovf_lvl", int'(fifo_level), 4);
      check("ovf_set", int'(overflow), 1);
      cycle(0, '0, 1, 1);
      check("ovf_clr", int'(overflow), 0);

      // full, push on the tick that pops
      idle_until_tick();
      cycle(1, 16'h2340, 1, 0);
      check("full_pp_lvl", int'(fifo_level), 4);
      check("full_pp_ovf", int'(overflow), 0);

      // backpressure across two ticks
      repeat (25) cycle(0, '0, 0, 0);
      check("bp_lvl", int'(fifo_level), 4);
      cycle(0, '0, 1, 0);
      repeat (15) cycle(0, '0, 1, 0);

      // randomized traffic with varying input rate
      for (int b = 0; b < 15; b++) begin
         int unsigned rate;
         rate = $urandom_range(2, 20);
         for (int i = 0; i < 200; i++) begin
            if ($urandom % 900 == 0) do_reset(2);
            cycle(($urandom % rate) == 0, 16'($urandom),
                  ($urandom % 4) != 0, ($urandom % 40) == 0);
         end
      end

      check("sb_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
